rgb_fade_sequencer: RTL and testbench

RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

---
 rtl/rgb_fade_sequencer_pkg.sv | 19 +
 rtl/rgb_fade_sequencer_if.sv | 35 +++
 rtl/rgb_fade_sequencer_step_tick.sv | 31 +++
 rtl/rgb_fade_sequencer.sv | 118 +++++++++++
 tb/tb_rgb_fade_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types and constants for the RGB fade sequencer: FSM state encoding,
// palette geometry and a counter-width helper.
package rgb_fade_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } fade_state_t;

    localparam int PAL_DEPTH = 4;
    localparam int IDX_W     = 2;

    // A counter over 0..n-1 needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Control, palette-write and duty-output bundle of the RGB fade sequencer.
// The state field is the FSM's debug view.
interface rgb_fade_sequencer_if #(
    parameter int R = 8
);
    import rgb_fade_sequencer_pkg::*;

    // start, stop and wr_en are single-cycle strobes sampled on the rising
    // clock edge; there is no back-pressure, so every strobe is accepted.
    logic             start;
    logic             stop;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [R:0]       wr_red;
    logic [R:0]       wr_green;
    logic [R:0]       wr_blue;

    logic [R:0]       red_duty;
    logic [R:0]       green_duty;
    logic [R:0]       blue_duty;
    logic             busy;
    logic [IDX_W-1:0] idx;
    fade_state_t      state;

    modport master (
        output start, stop, wr_en, wr_addr, wr_red, wr_green, wr_blue,
        input  red_duty, green_duty, blue_duty, busy, idx, state
    );

    modport slave (
        input  start, stop, wr_en, wr_addr, wr_red, wr_green, wr_blue,
        output red_duty, green_duty, blue_duty, busy, idx, state
    );

endinterface

// File: rtl/rgb_fade_sequencer_step_tick.sv
// Fade-step prescaler: counts 0..STEP_DIV-1 while enabled and pulses tick on
// the last count; held at 0 while disabled.
module step_tick_gen
    import rgb_fade_sequencer_pkg::*;
#(
    parameter int STEP_DIV = 195
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Four-entry RGB palette sequencer: fades the three duty outputs one LSB per
// step tick toward palette[idx], dwells HOLD_STEPS ticks, then moves on.
module rgb_fade_sequencer
    import rgb_fade_sequencer_pkg::*;
#(
    parameter int R          = 8,
    parameter int STEP_DIV   = 195,
    parameter int HOLD_STEPS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    rgb_fade_sequencer_if.slave  bus
);

    localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};
    localparam int HC_W = cnt_width(HOLD_STEPS);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_STEPS - 1);

    fade_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [HC_W-1:0]  hold_cnt;
    logic [R:0]       duty_r, duty_g, duty_b;
    logic [R:0]       pal_r [PAL_DEPTH];
    logic [R:0]       pal_g [PAL_DEPTH];
    logic [R:0]       pal_b [PAL_DEPTH];
    logic             tick;

    function automatic logic [R:0] clamp(input logic [R:0] v);
        return (v > FULL) ? FULL : v;
    endfunction

    // One LSB toward the target; landing exactly on it rules out overshoot.
    function automatic logic [R:0] approach(input logic [R:0] cur, input logic [R:0] tgt);
        if (cur < tgt) return cur + (R+1)'(1);
        if (cur > tgt) return cur - (R+1)'(1);
        return cur;
    endfunction

    step_tick_gen #(.STEP_DIV(STEP_DIV)) u_step_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal_r[i] <= '0;
                pal_g[i] <= '0;
                pal_b[i] <= '0;
            end
        end else if (bus.wr_en) begin
            pal_r[bus.wr_addr] <= clamp(bus.wr_red);
            pal_g[bus.wr_addr] <= clamp(bus.wr_green);
            pal_b[bus.wr_addr] <= clamp(bus.wr_blue);
        end
    end

    logic [R:0] nxt_r, nxt_g, nxt_b;
    logic       reached;

    assign nxt_r   = approach(duty_r, pal_r[idx]);
    assign nxt_g   = approach(duty_g, pal_g[idx]);
    assign nxt_b   = approach(duty_b, pal_b[idx]);
    assign reached = (nxt_r == pal_r[idx]) && (nxt_g == pal_g[idx]) && (nxt_b == pal_b[idx]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            duty_r   <= '0;
            duty_g   <= '0;
            duty_b   <= '0;
        end else if (bus.stop) begin
            // Duties and idx freeze so a later start resumes the same fade.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) state <= ST_FADE;
                end
                ST_FADE: begin
                    if (tick) begin
                        duty_r <= nxt_r;
                        duty_g <= nxt_g;
                        duty_b <= nxt_b;
                        if (reached) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            idx      <= idx + IDX_W'(1);
                            state    <= ST_FADE;
                        end else begin
                            hold_cnt <= hold_cnt + HC_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.red_duty   = duty_r;
    assign bus.green_duty = duty_g;
    assign bus.blue_duty  = duty_b;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.idx        = idx;
    assign bus.state      = state;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer (R=8, STEP_DIV=4, HOLD_STEPS=2):
// a cycle model feeds an expected queue, scenario tasks add targeted checks.
module tb_rgb_fade_sequencer;
  import rgb_fade_sequencer_pkg::*;

  localparam int R  = 8;
  localparam int SD = 4;
  localparam int HS = 2;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rgb_fade_sequencer_if #(.R(R)) bus();

  rgb_fade_sequencer #(.R(R), .STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<1ms", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  fade_state_t m_state = ST_IDLE;
  int m_idx, m_r, m_g, m_b, m_cnt, m_hold;
  int m_pr[4], m_pg[4], m_pb[4];

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  function automatic int clip(input int v);
    return (v > 256) ? 256 : v;
  endfunction

  task automatic model_cycle();
    bit tk;
    int tr, tg, tb;
    if (rst) begin
      m_state = ST_IDLE;
      m_idx = 0; m_r = 0; m_g = 0; m_b = 0; m_cnt = 0; m_hold = 0;
      for (int i = 0; i < 4; i++) begin
        m_pr[i] = 0; m_pg[i] = 0; m_pb[i] = 0;
      end
      return;
    end
    tk = (m_state != ST_IDLE) && (m_cnt == SD - 1);
    tr = m_pr[m_idx]; tg = m_pg[m_idx]; tb = m_pb[m_idx];
    m_cnt = (m_state == ST_IDLE || tk) ? 0 : m_cnt + 1;
    if (bus.stop) begin
      m_state = ST_IDLE;
    end else if (m_state == ST_IDLE) begin
      if (bus.start) m_state = ST_FADE;
    end else if (m_state == ST_FADE) begin
      if (tk) begin
        m_r = toward(m_r, tr); m_g = toward(m_g, tg); m_b = toward(m_b, tb);
        if (m_r == tr && m_g == tg && m_b == tb) begin
          m_state = ST_HOLD;
          m_hold = 0;
        end
      end
    end else if (tk) begin
      if (m_hold == HS - 1) begin
        m_hold = 0;
        m_idx = (m_idx + 1) % 4;
        m_state = ST_FADE;
      end else begin
        m_hold++;
      end
    end
    if (bus.wr_en) begin
      m_pr[bus.wr_addr] = clip(int'(bus.wr_red));
      m_pg[bus.wr_addr] = clip(int'(bus.wr_green));
      m_pb[bus.wr_addr] = clip(int'(bus.wr_blue));
    end
  endtask

  // ---------------- driver: one clock with scoreboard ----------------
  task automatic step();
    logic [W-1:0] e, got;
    model_cycle();
    exp_q.push_back({2'(m_state), (m_state != ST_IDLE), 2'(m_idx), 9'(m_r), 9'(m_g), 9'(m_b)});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.wr_en = 1'b0;
    got = {bus.state, bus.busy, bus.idx, bus.red_duty, bus.green_duty, bus.blue_duty};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t got st=%0d busy=%0d idx=%0d rgb=%0d,%0d,%0d exp st=%0d busy=%0d idx=%0d rgb=%0d,%0d,%0d",
               $time, got[31:30], got[29], got[28:27], got[26:18], got[17:9], got[8:0],
               e[31:30], e[29], e[28:27], e[26:18], e[17:9], e[8:0]);
    end
  endtask

  task automatic wr(input int a, input int r, input int g, input int b);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 2'(a);
    bus.wr_red   = 9'(r);
    bus.wr_green = 9'(g);
    bus.wr_blue  = 9'(b);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step();
    step();
    checks++;
    if (bus.state !== ST_IDLE || bus.busy !== 1'b0 || bus.idx !== 2'd0 || bus.red_duty !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got st=%0d busy=%0d idx=%0d r=%0d exp 0,0,0,0", bus.state, bus.busy, bus.idx, bus.red_duty);
    end
    rst = 1'b0;
    step();
    wr(0, 0, 0, 0);
    wr(1, 5, 5, 5);
    bus.start = 1'b1;
    step();
    repeat (20) step();
    checks++;
    if (bus.idx !== 2'd1 || bus.red_duty !== 9'd2) begin
      errors++;
      $display("FAIL mid_fade_setup got idx=%0d r=%0d exp idx=1 r=2", bus.idx, bus.red_duty);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.red_duty, bus.green_duty, bus.blue_duty} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset_duty got %0d,%0d,%0d exp 0,0,0", bus.red_duty, bus.green_duty, bus.blue_duty);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.idx !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_ctl got busy=%0d idx=%0d exp busy=0 idx=0", bus.busy, bus.idx);
    end
    step();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_after_reset got st=%0d exp %0d", bus.state, ST_IDLE);
    end
    bus.start = 1'b1;
    step();
    repeat (3) step();
    checks++;
    if (bus.state !== ST_FADE) begin
      errors++;
      $display("FAIL before_first_tick got st=%0d exp %0d", bus.state, ST_FADE);
    end
    step();
    checks++;
    if (bus.state !== ST_HOLD) begin
      errors++;
      $display("FAIL hold_after_first_tick got st=%0d exp %0d", bus.state, ST_HOLD);
    end
    bus.stop = 1'b1;
    step();
  endtask

  task automatic test_fade_up();
    do_reset();
    wr(0, 10, 0, 3);
    bus.start = 1'b1;
    step();
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 4) begin
        checks++;
        if (bus.red_duty !== 9'd1) begin
          errors++;
          $display("FAIL fade_up_tick1 got r=%0d exp 1", bus.red_duty);
        end
      end
      if (n == 12) begin
        checks++;
        if (bus.blue_duty !== 9'd3 || bus.red_duty !== 9'd3 || bus.state !== ST_FADE) begin
          errors++;
          $display("FAIL fade_up_tick3 got r=%0d b=%0d st=%0d exp r=3 b=3 st=1", bus.red_duty, bus.blue_duty, bus.state);
        end
      end
      if (n == 39) begin
        checks++;
        if (bus.red_duty !== 9'd9 || bus.state !== ST_FADE) begin
          errors++;
          $display("FAIL fade_up_cycle39 got r=%0d st=%0d exp r=9 st=1", bus.red_duty, bus.state);
        end
      end
    end
    checks++;
    if (bus.red_duty !== 9'd10 || bus.green_duty !== 9'd0 || bus.blue_duty !== 9'd3 || bus.state !== ST_HOLD) begin
      errors++;
      $display("FAIL fade_up_cycle40 got rgb=%0d,%0d,%0d st=%0d exp 10,0,3 st=2",
               bus.red_duty, bus.green_duty, bus.blue_duty, bus.state);
    end
    bus.stop = 1'b1;
    step();
  endtask

  task automatic test_clamp_fade_down();
    int n, bad;
    logic [R:0] prev;
    do_reset();
    wr(1, 300, 0, 0);
    bus.start = 1'b1;
    step();
    n = 0;
    while (bus.state !== ST_HOLD && n < 40) begin step(); n++; end
    n = 0;
    while (bus.state !== ST_FADE && n < 40) begin step(); n++; end
    n = 0;
    while (bus.state !== ST_HOLD && n < 1100) begin step(); n++; end
    checks++;
    if (bus.red_duty !== 9'd256 || bus.idx !== 2'd1 || bus.state !== ST_HOLD) begin
      errors++;
      $display("FAIL clamp_256 got r=%0d idx=%0d st=%0d exp r=256 idx=1 st=2", bus.red_duty, bus.idx, bus.state);
    end
    n = 0;
    while (bus.state !== ST_FADE && n < 40) begin step(); n++; end
    n = 0;
    bad = 0;
    prev = bus.red_duty;
    while (bus.state !== ST_HOLD && n < 1100) begin
      step();
      n++;
      if (bus.red_duty > 9'd256 || bus.red_duty > prev) bad++;
      prev = bus.red_duty;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fade_down_monotonic got %0d violations exp 0", bad);
    end
    checks++;
    if (bus.red_duty !== 9'd0 || bus.idx !== 2'd2 || bus.state !== ST_HOLD || n < 1000 || n > 1030) begin
      errors++;
      $display("FAIL fade_down_end got r=%0d idx=%0d st=%0d cycles=%0d exp r=0 idx=2 st=2 cycles~1024",
               bus.red_duty, bus.idx, bus.state, n);
    end
    bus.stop = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    int exp_idx[4] = '{1, 2, 3, 0};
    int exits, hold_len, n;
    do_reset();
    wr(0, 1, 0, 0);
    wr(1, 0, 2, 0);
    wr(2, 0, 0, 1);
    wr(3, 1, 1, 1);
    bus.start = 1'b1;
    step();
    checks++;
    if (bus.idx !== 2'd0 || bus.state !== ST_FADE) begin
      errors++;
      $display("FAIL wrap_start got idx=%0d st=%0d exp idx=0 st=1", bus.idx, bus.state);
    end
    exits = 0;
    hold_len = 0;
    n = 0;
    while (exits < 4 && n < 400) begin
      step();
      n++;
      if (bus.state == ST_HOLD) begin
        hold_len++;
      end else if (hold_len > 0) begin
        checks++;
        if (hold_len != 8) begin
          errors++;
          $display("FAIL hold_length exit=%0d got %0d cycles exp 8", exits, hold_len);
        end
        checks++;
        if (int'(bus.idx) != exp_idx[exits]) begin
          errors++;
          $display("FAIL idx_sequence exit=%0d got %0d exp %0d", exits, bus.idx, exp_idx[exits]);
        end
        exits++;
        hold_len = 0;
      end
    end
    checks++;
    if (exits != 4) begin
      errors++;
      $display("FAIL wrap_timeout got %0d hold exits exp 4", exits);
    end
    bus.stop = 1'b1;
    step();
  endtask

  task automatic test_collision();
    do_reset();
    wr(0, 20, 20, 20);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    checks++;
    if (bus.state !== ST_IDLE || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_same_cycle got st=%0d busy=%0d exp st=0 busy=0", bus.state, bus.busy);
    end
    bus.start = 1'b1;
    step();
    repeat (12) step();
    bus.stop = 1'b1;
    step();
    checks++;
    if (bus.state !== ST_IDLE || bus.red_duty !== 9'd3 || bus.blue_duty !== 9'd3 || bus.idx !== 2'd0) begin
      errors++;
      $display("FAIL stop_freeze got st=%0d r=%0d b=%0d idx=%0d exp st=0 r=3 b=3 idx=0",
               bus.state, bus.red_duty, bus.blue_duty, bus.idx);
    end
    repeat (10) step();
    checks++;
    if (bus.red_duty !== 9'd3) begin
      errors++;
      $display("FAIL idle_no_change got r=%0d exp 3", bus.red_duty);
    end
    bus.start = 1'b1;
    step();
    step();
    bus.start = 1'b1;
    step();
    step();
    step();
    checks++;
    if (bus.red_duty !== 9'd4 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL resume_after_stop got r=%0d busy=%0d exp r=4 busy=1", bus.red_duty, bus.busy);
    end
    bus.stop = 1'b1;
    step();
  endtask

  task automatic test_live_write();
    do_reset();
    wr(0, 10, 10, 10);
    bus.start = 1'b1;
    step();
    repeat (12) step();
    checks++;
    if (bus.green_duty !== 9'd3) begin
      errors++;
      $display("FAIL live_pre got g=%0d exp 3", bus.green_duty);
    end
    wr(0, 0, 0, 0);
    repeat (3) step();
    checks++;
    if (bus.red_duty !== 9'd2 || bus.green_duty !== 9'd2 || bus.state !== ST_FADE) begin
      errors++;
      $display("FAIL live_redirect got r=%0d g=%0d st=%0d exp r=2 g=2 st=1", bus.red_duty, bus.green_duty, bus.state);
    end
    repeat (8) step();
    checks++;
    if (bus.blue_duty !== 9'd0 || bus.state !== ST_HOLD) begin
      errors++;
      $display("FAIL live_reach_hold got b=%0d st=%0d exp b=0 st=2", bus.blue_duty, bus.state);
    end
    bus.stop = 1'b1;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 2'd0;
    bus.wr_red   = '0;
    bus.wr_green = '0;
    bus.wr_blue  = '0;
    test_reset();
    test_fade_up();
    test_clamp_fade_down();
    test_wrap();
    test_collision();
    test_live_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
